ex_mem_wb_pipe: RTL and testbench

- EX/MEM and MEM/WB pipeline registers of the 5-stage MIPS core, with the data-memory access sequencer between them.
- Directly feeds the forwarding control unit with EX_MEM_rd, EX_MEM_regWrite, MEM_WB_rd, MEM_WB_rt and MEM_WB_regWrite.
- Drives a variable-latency data memory with a req/ready handshake and stalls the upstream stages while an access is outstanding.

---
 rtl/ex_mem_wb_pipe.sv | 140 ++++++++++++++
 tb/tb_ex_mem_wb_pipe.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_wb_pipe.sv
// EX/MEM and MEM/WB pipeline registers with the data-memory req/ready sequencer between them.
// Optional stall-cycle counter is built when STALL_COUNT_EN is defined.
module ex_mem_wb_pipe #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic              ex_regWrite,
    input  logic              ex_memRead,
    input  logic              ex_memWrite,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic [REG_W-1:0]  ex_rt,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic              flush,
    input  logic              dmem_ready,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic              stall_out,
    output logic              EX_MEM_regWrite,
    output logic [REG_W-1:0]  EX_MEM_rd,
    output logic [DATA_W-1:0] EX_MEM_alu_result,
    output logic              MEM_WB_regWrite,
    output logic [REG_W-1:0]  MEM_WB_rd,
    output logic [REG_W-1:0]  MEM_WB_rt,
    output logic [DATA_W-1:0] MEM_WB_wdata,
    output logic [31:0]       stall_cycles
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t              state;
    logic                mem_valid;
    logic                mem_read;
    logic                mem_write;
    logic [REG_W-1:0]    mem_rt;
    logic [DATA_W-1:0]   mem_store_data;

    assign dmem_req   = mem_valid && (mem_read || mem_write) &&
                        (state == S_IDLE || state == S_WAIT);
    assign stall_out  = dmem_req && !dmem_ready;
    assign dmem_we    = mem_write;
    assign dmem_addr  = EX_MEM_alu_result;
    assign dmem_wdata = mem_store_data;

    // A load's rd is zeroed because its data only exists after MEM, so forwarding must never pick it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_valid         <= 1'b0;
            EX_MEM_regWrite   <= 1'b0;
            mem_read          <= 1'b0;
            mem_write         <= 1'b0;
            EX_MEM_rd         <= '0;
            mem_rt            <= '0;
            EX_MEM_alu_result <= '0;
            mem_store_data    <= '0;
        end else if (!stall_out) begin
            if (flush || !ex_valid) begin
                mem_valid         <= 1'b0;
                EX_MEM_regWrite   <= 1'b0;
                mem_read          <= 1'b0;
                mem_write         <= 1'b0;
                EX_MEM_rd         <= '0;
                mem_rt            <= '0;
                EX_MEM_alu_result <= '0;
                mem_store_data    <= '0;
            end else begin
                mem_valid         <= 1'b1;
                EX_MEM_regWrite   <= ex_regWrite;
                mem_read          <= ex_memRead;
                mem_write         <= ex_memWrite;
                EX_MEM_rd         <= ex_memRead ? '0 : ex_rd;
                mem_rt            <= ex_rt;
                EX_MEM_alu_result <= ex_alu_result;
                mem_store_data    <= ex_store_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (dmem_req && !dmem_ready) state <= S_WAIT;
                S_WAIT:  if (!dmem_req || dmem_ready) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // wdata is left untouched on bubbles; regWrite=0 already makes it irrelevant downstream.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            MEM_WB_regWrite <= 1'b0;
            MEM_WB_rd       <= '0;
            MEM_WB_rt       <= '0;
            MEM_WB_wdata    <= '0;
        end else if (stall_out || !mem_valid || (mem_write && !mem_read)) begin
            MEM_WB_regWrite <= 1'b0;
            MEM_WB_rd       <= '0;
            MEM_WB_rt       <= '0;
        end else if (mem_read) begin
            MEM_WB_regWrite <= 1'b1;
            MEM_WB_rd       <= '0;
            MEM_WB_rt       <= mem_rt;
            MEM_WB_wdata    <= dmem_rdata;
        end else begin
            MEM_WB_regWrite <= EX_MEM_regWrite;
            MEM_WB_rd       <= EX_MEM_rd;
            MEM_WB_rt       <= '0;
            MEM_WB_wdata    <= EX_MEM_alu_result;
        end
    end

`ifdef STALL_COUNT_EN
    logic [31:0] stall_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
        end else if (stall_out && stall_count != 32'hFFFF_FFFF) begin
            stall_count <= stall_count + 32'd1;
        end
    end

    assign stall_cycles = stall_count;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_ex_mem_wb_pipe.sv
// Scoreboard bench for ex_mem_wb_pipe: directed instructions push expected writebacks and
// memory accesses into queues; a monitor pops and compares whenever the DUT presents them.
module tb_ex_mem_wb_pipe;

    typedef struct packed {
        logic [4:0]  rd;
        logic [4:0]  rt;
        logic [31:0] data;
    } wb_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid, ex_regWrite, ex_memRead, ex_memWrite, flush;
    logic [4:0]  ex_rd, ex_rt;
    logic [31:0] ex_alu_result, ex_store_data;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        dmem_req, dmem_we, stall_out;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        EX_MEM_regWrite, MEM_WB_regWrite;
    logic [4:0]  EX_MEM_rd, MEM_WB_rd, MEM_WB_rt;
    logic [31:0] EX_MEM_alu_result, MEM_WB_wdata, stall_cycles;

    int   checks   = 0;
    int   failures = 0;
    wb_t  wbQ[$];
    mem_t memQ[$];

    ex_mem_wb_pipe #(.DATA_W(32), .REG_W(5)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead),
        .ex_memWrite(ex_memWrite), .ex_rd(ex_rd), .ex_rt(ex_rt),
        .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data), .flush(flush),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .stall_out(stall_out),
        .EX_MEM_regWrite(EX_MEM_regWrite), .EX_MEM_rd(EX_MEM_rd),
        .EX_MEM_alu_result(EX_MEM_alu_result),
        .MEM_WB_regWrite(MEM_WB_regWrite), .MEM_WB_rd(MEM_WB_rd), .MEM_WB_rt(MEM_WB_rt),
        .MEM_WB_wdata(MEM_WB_wdata), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic rw, input logic mr, input logic mw,
                                 input logic [4:0] rd, input logic [4:0] rt,
                                 input logic [31:0] alu, input logic [31:0] sd, input logic fl);
        ex_valid      = v;
        ex_regWrite   = rw;
        ex_memRead    = mr;
        ex_memWrite   = mw;
        ex_rd         = rd;
        ex_rt         = rt;
        ex_alu_result = alu;
        ex_store_data = sd;
        flush         = fl;
    endtask

    task automatic expectWb(input logic [4:0] rd, input logic [4:0] rt, input logic [31:0] data);
        wb_t e;
        e.rd = rd; e.rt = rt; e.data = data;
        wbQ.push_back(e);
    endtask

    task automatic expectMem(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        mem_t e;
        e.we = we; e.addr = addr; e.wdata = wdata;
        memQ.push_back(e);
    endtask

    task automatic cycle();
        @(negedge clk);
        #1;
    endtask

    // Monitor samples mid-cycle, after the stimulus for the coming edge has settled.
    initial begin
        wb_t  w;
        mem_t m;
        forever begin
            @(negedge clk);
            #3;
            if (!reset && dmem_req && dmem_ready) begin
                if (memQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL mon_unexpected_dmem actual addr=0x%0h required=no access", dmem_addr);
                end else begin
                    m = memQ.pop_front();
                    checkOutput("mon_dmem_we", {31'd0, dmem_we}, {31'd0, m.we});
                    checkOutput("mon_dmem_addr", dmem_addr, m.addr);
                    checkOutput("mon_dmem_wdata", dmem_wdata, m.wdata);
                end
            end
            if (MEM_WB_regWrite) begin
                if (wbQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL mon_unexpected_wb actual wdata=0x%0h required=no writeback", MEM_WB_wdata);
                end else begin
                    w = wbQ.pop_front();
                    checkOutput("mon_wb_rd", {27'd0, MEM_WB_rd}, {27'd0, w.rd});
                    checkOutput("mon_wb_rt", {27'd0, MEM_WB_rt}, {27'd0, w.rt});
                    checkOutput("mon_wb_wdata", MEM_WB_wdata, w.data);
                end
            end
        end
    end

    initial begin
        reset      = 1'b1;
        dmem_ready = 1'b0;
        dmem_rdata = '0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset state
        cycle();
        cycle();
        checkOutput("rst_req", {31'd0, dmem_req}, 0);
        checkOutput("rst_stall", {31'd0, stall_out}, 0);
        checkOutput("rst_exmem_rw", {31'd0, EX_MEM_regWrite}, 0);
        checkOutput("rst_memwb_rw", {31'd0, MEM_WB_regWrite}, 0);
        checkOutput("rst_memwb_wdata", MEM_WB_wdata, 0);
        checkOutput("rst_stall_cycles", stall_cycles, 0);
        reset = 1'b0;

        // Zero-wait memory: add $5=7 then lw $6 with ready held high
        dmem_ready = 1'b1;
        dmem_rdata = 32'h55;
        cycle();
        applyStimulus(1, 1, 0, 0, 5'd5, 5'd0, 32'd7, 0, 0);
        expectWb(5'd5, 5'd0, 32'd7);
        cycle();
        checkOutput("add_exmem_rd", {27'd0, EX_MEM_rd}, 5);
        checkOutput("add_exmem_rw", {31'd0, EX_MEM_regWrite}, 1);
        checkOutput("add_exmem_alu", EX_MEM_alu_result, 7);
        checkOutput("add_stall", {31'd0, stall_out}, 0);
        applyStimulus(1, 1, 1, 0, 5'd9, 5'd6, 32'h20, 0, 0);
        expectWb(5'd0, 5'd6, 32'h55);
        expectMem(1'b0, 32'h20, 32'h0);
        cycle();
        checkOutput("lw0_exmem_rd", {27'd0, EX_MEM_rd}, 0);
        checkOutput("lw0_req", {31'd0, dmem_req}, 1);
        checkOutput("lw0_stall", {31'd0, stall_out}, 0);
        checkOutput("add_memwb_rd", {27'd0, MEM_WB_rd}, 5);
        checkOutput("add_memwb_wdata", MEM_WB_wdata, 7);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        checkOutput("lw0_memwb_rt", {27'd0, MEM_WB_rt}, 6);
        checkOutput("lw0_memwb_rd", {27'd0, MEM_WB_rd}, 0);
        checkOutput("lw0_memwb_wdata", MEM_WB_wdata, 32'h55);

        // Load to 0x40 with 3 wait cycles
        dmem_ready = 1'b0;
        applyStimulus(1, 1, 1, 0, 5'd0, 5'd8, 32'h40, 0, 0);
        expectWb(5'd0, 5'd8, 32'h1234);
        expectMem(1'b0, 32'h40, 32'h0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            checkOutput("ld3_req", {31'd0, dmem_req}, 1);
            checkOutput("ld3_addr", dmem_addr, 32'h40);
            if (i == 0) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
            if (i < 3) begin
                checkOutput("ld3_stall", {31'd0, stall_out}, 1);
                checkOutput("ld3_memwb_bubble", {31'd0, MEM_WB_regWrite}, 0);
            end else begin
                dmem_ready = 1'b1;
                dmem_rdata = 32'h1234;
                #1;
                checkOutput("ld3_stall_release", {31'd0, stall_out}, 0);
            end
        end
        cycle();
        dmem_ready = 1'b0;
        checkOutput("ld3_req_drop", {31'd0, dmem_req}, 0);
        checkOutput("ld3_memwb_rt", {27'd0, MEM_WB_rt}, 8);
        checkOutput("ld3_memwb_wdata", MEM_WB_wdata, 32'h1234);
`ifdef STALL_COUNT_EN
        checkOutput("ld3_stall_cycles", stall_cycles, 3);
`else
        checkOutput("ld3_stall_cycles_off", stall_cycles, 0);
`endif

        // Store 0xDEAD to 0x10 with 2 waits, immediately followed by a load to 0x44
        applyStimulus(1, 0, 0, 1, 5'd0, 5'd0, 32'h10, 32'hDEAD, 0);
        expectMem(1'b1, 32'h10, 32'hDEAD);
        for (int i = 0; i < 3; i++) begin
            cycle();
            checkOutput("st_req", {31'd0, dmem_req}, 1);
            checkOutput("st_we", {31'd0, dmem_we}, 1);
            checkOutput("st_addr", dmem_addr, 32'h10);
            checkOutput("st_wdata", dmem_wdata, 32'hDEAD);
            checkOutput("st_memwb_rw", {31'd0, MEM_WB_regWrite}, 0);
            if (i == 0) begin
                applyStimulus(1, 1, 1, 0, 5'd3, 5'd9, 32'h44, 0, 0);
                expectWb(5'd0, 5'd9, 32'h77);
                expectMem(1'b0, 32'h44, 32'h0);
            end
            if (i < 2) begin
                checkOutput("st_stall", {31'd0, stall_out}, 1);
            end else begin
                dmem_ready = 1'b1;
                dmem_rdata = 32'h77;
                #1;
                checkOutput("st_stall_release", {31'd0, stall_out}, 0);
            end
        end
        cycle();
        checkOutput("st_memwb_rw_after", {31'd0, MEM_WB_regWrite}, 0);
        checkOutput("stld_req", {31'd0, dmem_req}, 1);
        checkOutput("stld_we", {31'd0, dmem_we}, 0);
        checkOutput("stld_addr", dmem_addr, 32'h44);
        checkOutput("stld_exmem_rd", {27'd0, EX_MEM_rd}, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        dmem_ready = 1'b0;
        checkOutput("stld_memwb_rt", {27'd0, MEM_WB_rt}, 9);
        checkOutput("stld_memwb_wdata", MEM_WB_wdata, 32'h77);

        // Flush of a writing instruction, then flush during a stall
        applyStimulus(1, 1, 0, 0, 5'd12, 5'd0, 32'd1, 0, 1);
        cycle();
        checkOutput("flush_exmem_rw", {31'd0, EX_MEM_regWrite}, 0);
        checkOutput("flush_exmem_rd", {27'd0, EX_MEM_rd}, 0);
        applyStimulus(1, 1, 1, 0, 5'd0, 5'd10, 32'h50, 0, 0);
        expectWb(5'd0, 5'd10, 32'h99);
        expectMem(1'b0, 32'h50, 32'h0);
        cycle();
        checkOutput("fstall_stall", {31'd0, stall_out}, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        cycle();
        checkOutput("fstall_hold_req", {31'd0, dmem_req}, 1);
        checkOutput("fstall_hold_addr", dmem_addr, 32'h50);
        checkOutput("fstall_hold_rw", {31'd0, EX_MEM_regWrite}, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        dmem_ready = 1'b1;
        dmem_rdata = 32'h99;
        cycle();
        dmem_ready = 1'b0;
        checkOutput("fstall_memwb_rt", {27'd0, MEM_WB_rt}, 10);

        // rd=0 with regWrite=1 flows through without stalling
        applyStimulus(1, 1, 0, 0, 5'd0, 5'd0, 32'd3, 0, 0);
        expectWb(5'd0, 5'd0, 32'd3);
        cycle();
        checkOutput("rd0_stall", {31'd0, stall_out}, 0);
        checkOutput("rd0_exmem_rw", {31'd0, EX_MEM_regWrite}, 1);
        checkOutput("rd0_exmem_rd", {27'd0, EX_MEM_rd}, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        checkOutput("rd0_memwb_rw", {31'd0, MEM_WB_regWrite}, 1);
        checkOutput("rd0_memwb_rd", {27'd0, MEM_WB_rd}, 0);

        // Reset asserted while a load waits; the access is abandoned
        applyStimulus(1, 1, 1, 0, 5'd0, 5'd11, 32'h60, 0, 0);
        cycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rstw_stall", {31'd0, stall_out}, 1);
        cycle();
        checkOutput("rstw_wait_stall", {31'd0, stall_out}, 1);
        reset = 1'b1;
        #1;
        checkOutput("rstw_req", {31'd0, dmem_req}, 0);
        checkOutput("rstw_stall_now", {31'd0, stall_out}, 0);
        checkOutput("rstw_addr", dmem_addr, 0);
        checkOutput("rstw_exmem_rw", {31'd0, EX_MEM_regWrite}, 0);
        checkOutput("rstw_exmem_alu", EX_MEM_alu_result, 0);
        checkOutput("rstw_memwb_rw", {31'd0, MEM_WB_regWrite}, 0);
        checkOutput("rstw_memwb_wdata", MEM_WB_wdata, 0);
        checkOutput("rstw_stall_cycles", stall_cycles, 0);
        dmem_ready = 1'b1;
        dmem_rdata = 32'hBAD;
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checkOutput("rstw_no_wb", {31'd0, MEM_WB_regWrite}, 0);
            checkOutput("rstw_no_req", {31'd0, dmem_req}, 0);
        end
        dmem_ready = 1'b0;

        cycle();
        cycle();
        checkOutput("wbq_drained", wbQ.size(), 0);
        checkOutput("memq_drained", memQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
